cpu_step_controller: RTL and testbench

//   Sequences the MIPS core clock-enable from debounced front-panel buttons.

---
 rtl/cpu_step_controller.sv | 123 ++++++++++++
 tb/tb_cpu_step_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_controller.sv
// rtl/cpu_step_controller.sv - CPU clock-enable sequencer: halt, single-step, auto-repeat step, free-run
// Outputs are registered from the current state, so every transition shows on the outputs one edge later.
module cpu_step_controller #(
  parameter int HOLD_CYCLES   = 12_500_000,
  parameter int REPEAT_CYCLES = 2_500_000,
  parameter int TIMER_WIDTH   = 24,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   step_button,
  input  logic                   run_button,
  input  logic                   halt_request,
  output logic                   cpu_enable,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] step_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_HOLD,
    S_REPEAT,
    S_RUN
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] HOLD_LAST   = TIMER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] REPEAT_LAST = TIMER_WIDTH'(REPEAT_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_step_prev;
  logic                   r_run_prev;
  logic                   r_cpu_enable;
  logic                   r_running;
  logic [COUNT_WIDTH-1:0] r_step_count;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] w_next_timer;
  logic                   w_next_enable;
  logic                   w_next_running;
  logic                   w_step_rise;
  logic                   w_run_rise;

  assign w_step_rise = step_button & ~r_step_prev;
  assign w_run_rise  = run_button & ~r_run_prev;

  always_comb begin
    w_next_state   = r_state;
    w_next_timer   = r_timer;
    w_next_enable  = 1'b0;
    w_next_running = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_run_rise) begin
          if (!halt_request) w_next_state = S_RUN;
        end else if (w_step_rise) begin
          w_next_state = S_STEP;
        end
      end
      S_STEP: begin
        w_next_enable = 1'b1;
        w_next_timer  = '0;
        w_next_state  = S_HOLD;
      end
      S_HOLD: begin
        if (!step_button) begin
          w_next_timer = '0;
          w_next_state = S_IDLE;
        end else if (r_timer == HOLD_LAST) begin
          w_next_enable = 1'b1;
          w_next_timer  = '0;
          w_next_state  = S_REPEAT;
        end else begin
          w_next_timer = r_timer + TIMER_WIDTH'(1);
        end
      end
      S_REPEAT: begin
        if (!step_button) begin
          w_next_timer = '0;
          w_next_state = S_IDLE;
        end else if (r_timer == REPEAT_LAST) begin
          w_next_enable = 1'b1;
          w_next_timer  = '0;
        end else begin
          w_next_timer = r_timer + TIMER_WIDTH'(1);
        end
      end
      S_RUN: begin
        w_next_enable  = 1'b1;
        w_next_running = 1'b1;
        // halt wins over a simultaneous run press; both simply drop to IDLE
        if (halt_request || w_run_rise) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Edge history resets high so a button held through reset never counts as a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step_prev  <= 1'b1;
      r_run_prev   <= 1'b1;
      r_cpu_enable <= 1'b0;
      r_running    <= 1'b0;
      r_step_count <= '0;
      r_timer      <= '0;
    end else begin
      r_state      <= w_next_state;
      r_step_prev  <= step_button;
      r_run_prev   <= run_button;
      r_cpu_enable <= w_next_enable;
      r_running    <= w_next_running;
      r_step_count <= r_step_count + {{(COUNT_WIDTH-1){1'b0}}, w_next_enable};
      r_timer      <= w_next_timer;
    end
  end

  assign cpu_enable = r_cpu_enable;
  assign running    = r_running;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
// tb/tb_cpu_step_controller.sv - directed bench for cpu_step_controller (HOLD=8, REPEAT=4, COUNT_WIDTH=4)
module tb_cpu_step_controller;

  logic       clock;
  logic       reset;
  logic       step_button;
  logic       run_button;
  logic       halt_request;
  logic       cpu_enable;
  logic       running;
  logic [3:0] step_count;

  int checks   = 0;
  int failures = 0;

  cpu_step_controller #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .TIMER_WIDTH  (24),
    .COUNT_WIDTH  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .step_button (step_button),
    .run_button  (run_button),
    .halt_request(halt_request),
    .cpu_enable  (cpu_enable),
    .running     (running),
    .step_count  (step_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic en, input logic run, input logic [3:0] cnt);
    chk({tag, "_en"}, {31'd0, cpu_enable}, {31'd0, en});
    chk({tag, "_run"}, {31'd0, running}, {31'd0, run});
    chk({tag, "_cnt"}, {28'd0, step_count}, {28'd0, cnt});
  endtask

  initial begin
    logic exp_en;
    reset        = 1'b1;
    step_button  = 1'b0;
    run_button   = 1'b0;
    halt_request = 1'b0;
    #2;
    chk_out("reset", 1'b0, 1'b0, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk_out("idle", 1'b0, 1'b0, 4'd0);

    // single step
    step_button = 1'b1;
    tick();
    chk_out("step_rise", 1'b0, 1'b0, 4'd0);
    step_button = 1'b0;
    tick();
    chk_out("step_pulse", 1'b1, 1'b0, 4'd1);
    tick();
    chk_out("step_after", 1'b0, 1'b0, 4'd1);
    tick();

    // step held 30 cycles: pulses at t=1, 9, 13, ..., 29
    step_button = 1'b1;
    for (int t = 0; t < 35; t++) begin
      tick();
      exp_en = (t == 1) || (t >= 9 && t <= 29 && ((t - 9) % 4) == 0);
      chk($sformatf("hold_t%0d", t), {31'd0, cpu_enable}, {31'd0, exp_en});
      if (t == 29) step_button = 1'b0;
    end
    chk_out("hold_end", 1'b0, 1'b0, 4'd8);

    // run for 10 cycles with step held (ignored)
    run_button = 1'b1;
    tick();
    chk_out("run_rise", 1'b0, 1'b0, 4'd8);
    run_button  = 1'b0;
    step_button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk({"run_en"}, {31'd0, cpu_enable}, 32'd1);
      chk({"run_running"}, {31'd0, running}, 32'd1);
      run_button = (i == 9);
    end
    run_button = 1'b0;
    tick();
    chk_out("run_stop", 1'b0, 1'b0, 4'd2);
    step_button = 1'b0;
    tick();
    chk_out("run_idle", 1'b0, 1'b0, 4'd2);

    // halt_request stops RUN; run refused while halted
    run_button = 1'b1;
    tick();
    run_button = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    chk_out("halt_pre", 1'b1, 1'b1, 4'd6);
    halt_request = 1'b1;
    tick();
    chk_out("halt_edge", 1'b1, 1'b1, 4'd7);
    tick();
    chk_out("halt_stop", 1'b0, 1'b0, 4'd7);
    run_button = 1'b1;
    tick();
    run_button = 1'b0;
    tick();
    tick();
    chk_out("halt_refuse", 1'b0, 1'b0, 4'd7);
    halt_request = 1'b0;
    tick();

    // step and run rise together: run wins
    step_button = 1'b1;
    run_button  = 1'b1;
    tick();
    step_button = 1'b0;
    run_button  = 1'b0;
    tick();
    chk_out("both_1", 1'b1, 1'b1, 4'd8);
    tick();
    chk_out("both_2", 1'b1, 1'b1, 4'd9);
    run_button = 1'b1;
    tick();
    run_button = 1'b0;
    tick();
    chk_out("both_stop", 1'b0, 1'b0, 4'd10);

    // reset released with step held: no pulse until re-pressed
    reset       = 1'b1;
    step_button = 1'b1;
    #2;
    chk_out("rst_held", 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("rst_held_en", {31'd0, cpu_enable}, 32'd0);
    end
    step_button = 1'b0;
    tick();
    step_button = 1'b1;
    tick();
    step_button = 1'b0;
    tick();
    chk_out("repress", 1'b1, 1'b0, 4'd1);
    tick();

    // 17 enabled cycles wrap the counter to 1
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    run_button = 1'b1;
    tick();
    run_button = 1'b0;
    for (int i = 1; i <= 16; i++) tick();
    chk_out("wrap_16", 1'b1, 1'b1, 4'd0);
    run_button = 1'b1;
    tick();
    run_button = 1'b0;
    tick();
    chk_out("wrap_17", 1'b0, 1'b0, 4'd1);

    // async reset mid-RUN
    run_button = 1'b1;
    tick();
    run_button = 1'b0;
    tick();
    tick();
    tick();
    chk_out("mid_run", 1'b1, 1'b1, 4'd4);
    reset = 1'b1;
    #2;
    chk_out("async_rst", 1'b0, 1'b0, 4'd0);
    tick();
    reset = 1'b0;
    tick();
    chk_out("post_rst", 1'b0, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
